dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Posted-write FIFO between the write-through data cache and data memory.
- Accepts cache write-throughs in a single cycle, so the cache no longer stalls the pipeline for every store.
- Drains stores to memory one at a time using the memory's write handshake.
- Arbitrates read-miss line fills against pending stores with a drain-before-read policy, so a fill never returns stale data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- cache_wr_valid  in  1  cache requests a write-through this cycle.
- cache_wr_addr  in  ADDR_W  store address.
- cache_wr_data  in  DATA_W  store data.
- cache_wr_ready  out  1  buffer not full; a push is accepted only when both cache_wr_valid and cache_wr_ready are high.
- cache_rd_miss  in  1  cache read miss; the cache holds it high, with a stable address, until cache_rd_ready.
- cache_rd_addr  in  ADDR_W  miss address.
- cache_rd_ready  out  1  one-cycle pulse when memory delivers the line.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  store data to memory.
- mem_write  out  1  write-through request to memory.
- mem_write_ready  in  1  memory write complete, one-cycle pulse.
- mem_read_miss  out  1  line-fill request to memory.
- mem_read_ready  in  1  line-fill data valid, one-cycle pulse; the cache takes the 128-bit line directly from memory.
- wb_empty  out  1  no pending stores; the hazard unit uses it.
- wb_count  out  $clog2(DEPTH+1)  number of pending stores.

Behaviour:
- Reset:
  - FIFO pointers and count are 0; state is IDLE.
  - mem_write, mem_read_miss and cache_rd_ready are 0; mem_addr and mem_wdata are 0.
  - cache_wr_ready is 1 and wb_empty is 1.
- Reset asserted mid-operation: all pending stores are discarded and all outputs take their reset values at the next edge. Memory shares Rst.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a registered count.
  - cache_wr_ready is ~full, decoded from the registered count.
  - There is no push-while-full bypass, even when a pop occurs in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
  - A push at edge t is visible in wb_count after edge t.
- State machine (Moore outputs):
  - IDLE:
    - If count==0 and cache_rd_miss, go to READ and latch cache_rd_addr.
    - Otherwise, if count!=0, go to WRITE.
    - Otherwise stay in IDLE.
    - A read miss with count!=0 waits in IDLE until the FIFO drains. Stores pushed while the miss waits are also drained first.
  - WRITE:
    - mem_write=1; mem_addr and mem_wdata come from the FIFO head and stay stable.
    - On mem_write_ready: pop the head and go to IDLE. This leaves one idle bubble between consecutive stores.
  - READ:
    - mem_read_miss=1; mem_addr is the latched miss address.
    - On mem_read_ready: cache_rd_ready=1 in that same cycle (combinational pass-through gated by READ), then go to IDLE.
- mem_write_ready is ignored outside WRITE; mem_read_ready is ignored outside READ.
- mem_addr and mem_wdata are 0 in IDLE.
- Pushes are accepted in every state.
- Latency: a store pushed into an empty buffer in IDLE at edge t raises mem_write after edge t+1.

Decomposition:
- Shared package dcache_wb_pkg:
  - state encoding: IDLE=2'd0, WRITE=2'd1, READ=2'd2;
  - default DEPTH, ADDR_W and DATA_W constants.
- One sub-module, wb_fifo: parameterised storage, pointers, count, full and empty.
- The top level holds the state machine, the miss-address latch and the output muxing.

Test Plan:
- Reset: assert Rst for 2 cycles, then release → wb_empty=1, wb_count=0, cache_wr_ready=1, mem_write=0, mem_read_miss=0, mem_addr=0.
- Single store: push addr 0x100, data 0xDEADBEEF at edge t; memory pulses mem_write_ready 3 cycles after mem_write rises.
  - mem_write rises after edge t+1.
  - mem_addr=0x100 and mem_wdata=0xDEADBEEF are held stable for the whole request.
  - Count returns to 0 and wb_empty=1 after the pop.
- Full and FIFO order: push 0x10, 0x14, 0x18, 0x1C with mem_write_ready held low.
  - cache_wr_ready=0 after the 4th push.
  - A 5th push of 0x20 is dropped and count stays 4.
  - Releasing memory drains 0x10, 0x14, 0x18, 0x1C in order and wraps the pointers.
  - Pushing 0x24 afterwards is accepted.
- Drain-before-read: with 2 stores pending, raise cache_rd_miss with addr 0x200.
  - mem_read_miss stays 0 until both stores complete.
  - Then mem_read_miss=1 with mem_addr=0x200.
  - A mem_read_ready pulse gives cache_rd_ready=1 in the same cycle, and the block is back in IDLE on the next cycle.
- Full with simultaneous pop: count 4, mem_write_ready pulse, and cache_wr_valid in the same cycle → the push is rejected and count becomes 3.
- Reset mid-operation: assert Rst while in WRITE with count 3 → after the edge mem_write=0, wb_count=0; a later mem_write_ready pulse is ignored.

Source files
------------

// File: rtl/dcache_wb_pkg.sv
// Shared definitions for the data-cache write buffer.
//   - Default geometry constants for the buffer and its interface.
//   - State encoding for the drain / line-fill arbiter.
//   - cnt_width(): width of a 0..depth occupancy count.
package dcache_wb_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } wb_state_e;

  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between the cache, the write buffer and data memory.
//   master : cache + memory side (drives requests, write/read completions)
//   slave  : write buffer side (drives memory requests, ready/status)
// Signals:
//   cache_wr_valid/addr/data, cache_wr_ready : store push handshake
//   cache_rd_miss/addr, cache_rd_ready       : line-fill request / done pulse
//   mem_addr, mem_wdata, mem_write           : memory request
//   mem_write_ready, mem_read_ready          : memory completion pulses
//   mem_read_miss                            : line-fill request to memory
//   wb_empty, wb_count                       : buffer occupancy status
interface dcache_write_buffer_if
  import dcache_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic              cache_wr_valid;
  logic [ADDR_W-1:0] cache_wr_addr;
  logic [DATA_W-1:0] cache_wr_data;
  logic              cache_wr_ready;
  logic              cache_rd_miss;
  logic [ADDR_W-1:0] cache_rd_addr;
  logic              cache_rd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_write_ready;
  logic              mem_read_miss;
  logic              mem_read_ready;
  logic              wb_empty;
  logic [CntW-1:0]   wb_count;

  modport master (
    output cache_wr_valid, cache_wr_addr, cache_wr_data, cache_rd_miss, cache_rd_addr,
    output mem_write_ready, mem_read_ready,
    input  cache_wr_ready, cache_rd_ready, mem_addr, mem_wdata, mem_write, mem_read_miss,
    input  wb_empty, wb_count
  );

  modport slave (
    input  cache_wr_valid, cache_wr_addr, cache_wr_data, cache_rd_miss, cache_rd_addr,
    input  mem_write_ready, mem_read_ready,
    output cache_wr_ready, cache_rd_ready, mem_addr, mem_wdata, mem_write, mem_read_miss,
    output wb_empty, wb_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular store FIFO for the write buffer.
//   clk, rst               : clock, synchronous active-high reset
//   push_valid/addr/data   : store offered by the cache
//   push_ready             : not full (no bypass when a pop coincides)
//   pop                    : retire the head entry
//   head_addr, head_data   : oldest pending store
//   count, empty           : registered occupancy
module wb_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CntW-1:0]   count,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full;
  logic              do_push;
  logic              do_pop;

  // Full is decoded from the registered count only, so a same-cycle pop never frees a slot.
  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = ~full;
  assign count      = count_q;
  assign do_push    = push_valid & ~full;
  assign do_pop     = pop & ~empty;
  assign head_addr  = addr_mem[rd_ptr_q];
  assign head_data  = data_mem[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between a write-through data cache and data memory.
// Stores are accepted in one cycle and drained one at a time; a read-miss
// line fill is only issued once every pending store (including ones pushed
// while the miss waits) has reached memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dcache_write_buffer_if (cache + memory signals)
module dcache_write_buffer
  import dcache_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic                 clk,
  input  logic                 rst,
  dcache_write_buffer_if.slave bus
);

  localparam int unsigned CntW = cnt_width(DEPTH);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CntW-1:0]   count;
  logic              empty;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.cache_wr_valid),
    .push_addr  (bus.cache_wr_addr),
    .push_data  (bus.cache_wr_data),
    .push_ready (bus.cache_wr_ready),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count),
    .empty      (empty)
  );

  assign bus.wb_empty = empty;
  assign bus.wb_count = count;

  // Next state. Pending stores always win over a waiting miss (drain-before-read).
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (empty && bus.cache_rd_miss) begin
          state_d     = StRead;
          miss_addr_d = bus.cache_rd_addr;
        end else if (!empty) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (bus.mem_write_ready) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      StRead: begin
        if (bus.mem_read_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs, except cache_rd_ready which forwards the fill pulse in READ.
  always_comb begin
    bus.mem_write      = 1'b0;
    bus.mem_read_miss  = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.cache_rd_ready = 1'b0;
    unique case (state_q)
      StWrite: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = head_addr;
        bus.mem_wdata = head_data;
      end
      StRead: begin
        bus.mem_read_miss  = 1'b1;
        bus.mem_addr       = miss_addr_q;
        bus.cache_rd_ready = bus.mem_read_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a store scoreboard: every
// accepted push is queued, and each memory write request is checked
// against the queue head for address, data and stability.
module tb_dcache_write_buffer;

  localparam int unsigned Depth = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;
  int model_count;
  logic [63:0] sb[$];

  dcache_write_buffer_if #(
    .DEPTH  (Depth),
    .ADDR_W (AddrW),
    .DATA_W (DataW)
  ) wb_if ();

  dcache_write_buffer #(
    .DEPTH  (Depth),
    .ADDR_W (AddrW),
    .DATA_W (DataW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data);
    logic accept;
    accept = (model_count < int'(Depth));
    chk("wr_ready_before_push", wb_if.cache_wr_ready, accept);
    wb_if.cache_wr_valid = 1'b1;
    wb_if.cache_wr_addr  = addr;
    wb_if.cache_wr_data  = data;
    step();
    wb_if.cache_wr_valid = 1'b0;
    if (accept) begin
      sb.push_back({addr, data});
      model_count++;
    end
  endtask

  // Wait for a write request, hold it delay+1 sampled cycles checking stability, then complete it.
  task automatic serve_write(input int delay);
    int n;
    logic [63:0] exp;
    n = 0;
    while (wb_if.mem_write !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("mem_write_seen", wb_if.mem_write, 1);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow observed=write_request expected=no_request");
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    for (int i = 0; i <= delay; i++) begin
      chk("mem_addr", wb_if.mem_addr, {32'h0, exp[63:32]});
      chk("mem_wdata", wb_if.mem_wdata, {32'h0, exp[31:0]});
      chk("no_read_during_write", wb_if.mem_read_miss, 0);
      if (i < delay) step();
    end
    wb_if.mem_write_ready = 1'b1;
    step();
    wb_if.mem_write_ready = 1'b0;
    model_count--;
    chk("count_after_pop", wb_if.wb_count, 64'(model_count));
    chk("write_dropped_after_pop", wb_if.mem_write, 0);
  endtask

  initial begin
    logic [63:0] head;
    int n;
    vectors     = 0;
    miscompares = 0;
    model_count = 0;
    rst                   = 1'b1;
    wb_if.cache_wr_valid  = 1'b0;
    wb_if.cache_wr_addr   = '0;
    wb_if.cache_wr_data   = '0;
    wb_if.cache_rd_miss   = 1'b0;
    wb_if.cache_rd_addr   = '0;
    wb_if.mem_write_ready = 1'b0;
    wb_if.mem_read_ready  = 1'b0;

    // Reset
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_empty", wb_if.wb_empty, 1);
    chk("rst_count", wb_if.wb_count, 0);
    chk("rst_wr_ready", wb_if.cache_wr_ready, 1);
    chk("rst_mem_write", wb_if.mem_write, 0);
    chk("rst_read_miss", wb_if.mem_read_miss, 0);
    chk("rst_mem_addr", wb_if.mem_addr, 0);
    chk("rst_mem_wdata", wb_if.mem_wdata, 0);
    chk("rst_rd_ready", wb_if.cache_rd_ready, 0);

    // Single store: mem_write one edge after the push edge
    push(32'h100, 32'hDEAD_BEEF);
    chk("single_count1", wb_if.wb_count, 1);
    chk("single_not_empty", wb_if.wb_empty, 0);
    chk("single_latency_low", wb_if.mem_write, 0);
    step();
    chk("single_latency_high", wb_if.mem_write, 1);
    serve_write(2);
    chk("single_empty", wb_if.wb_empty, 1);
    chk("single_idle_addr", wb_if.mem_addr, 0);

    // Full and FIFO order
    push(32'h10, 32'h1111_0010);
    push(32'h14, 32'h1111_0014);
    push(32'h18, 32'h1111_0018);
    push(32'h1C, 32'h1111_001C);
    chk("full_wr_ready", wb_if.cache_wr_ready, 0);
    chk("full_count", wb_if.wb_count, 4);
    push(32'h20, 32'h1111_0020);
    chk("full_drop_count", wb_if.wb_count, 4);
    serve_write(0);
    serve_write(0);
    serve_write(0);
    serve_write(0);
    chk("drained_empty", wb_if.wb_empty, 1);
    push(32'h24, 32'h1111_0024);
    chk("wrap_count", wb_if.wb_count, 1);
    serve_write(1);

    // Drain-before-read, with one more store pushed while the miss waits
    push(32'h30, 32'h2222_0030);
    push(32'h34, 32'h2222_0034);
    wb_if.cache_rd_miss = 1'b1;
    wb_if.cache_rd_addr = 32'h200;
    serve_write(1);
    push(32'h38, 32'h2222_0038);
    chk("miss_waits", wb_if.mem_read_miss, 0);
    serve_write(1);
    serve_write(1);
    chk("miss_after_drain_idle", wb_if.mem_read_miss, 0);
    step();
    chk("read_issued", wb_if.mem_read_miss, 1);
    chk("read_addr", wb_if.mem_addr, 64'h200);
    chk("read_no_write", wb_if.mem_write, 0);
    step();
    chk("read_held", wb_if.mem_read_miss, 1);
    chk("rd_ready_idle_low", wb_if.cache_rd_ready, 0);
    wb_if.mem_read_ready = 1'b1;
    #1;
    chk("rd_ready_pass", wb_if.cache_rd_ready, 1);
    step();
    wb_if.mem_read_ready = 1'b0;
    wb_if.cache_rd_miss  = 1'b0;
    chk("read_done_miss", wb_if.mem_read_miss, 0);
    chk("read_done_rdy", wb_if.cache_rd_ready, 0);
    chk("read_done_addr", wb_if.mem_addr, 0);

    // mem_read_ready outside READ is ignored
    wb_if.mem_read_ready = 1'b1;
    #1;
    chk("rd_ready_ignored", wb_if.cache_rd_ready, 0);
    step();
    wb_if.mem_read_ready = 1'b0;
    chk("no_spurious_read", wb_if.mem_read_miss, 0);

    // Full with simultaneous pop: push rejected
    push(32'h40, 32'h3333_0040);
    push(32'h44, 32'h3333_0044);
    push(32'h48, 32'h3333_0048);
    push(32'h4C, 32'h3333_004C);
    n = 0;
    while (wb_if.mem_write !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("fullpop_write", wb_if.mem_write, 1);
    chk("fullpop_count4", wb_if.wb_count, 4);
    head = sb.pop_front();
    chk("fullpop_head", wb_if.mem_addr, {32'h0, head[63:32]});
    wb_if.mem_write_ready = 1'b1;
    wb_if.cache_wr_valid  = 1'b1;
    wb_if.cache_wr_addr   = 32'h50;
    wb_if.cache_wr_data   = 32'h3333_0050;
    step();
    wb_if.mem_write_ready = 1'b0;
    wb_if.cache_wr_valid  = 1'b0;
    model_count--;
    chk("fullpop_count3", wb_if.wb_count, 64'(model_count));
    chk("fullpop_ready", wb_if.cache_wr_ready, 1);

    // Reset mid-operation while in WRITE with three stores pending
    step();
    chk("midrst_pre_write", wb_if.mem_write, 1);
    chk("midrst_pre_count", wb_if.wb_count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    model_count = 0;
    chk("midrst_write", wb_if.mem_write, 0);
    chk("midrst_count", wb_if.wb_count, 0);
    chk("midrst_empty", wb_if.wb_empty, 1);
    chk("midrst_addr", wb_if.mem_addr, 0);
    wb_if.mem_write_ready = 1'b1;
    step();
    wb_if.mem_write_ready = 1'b0;
    chk("midrst_ignore_count", wb_if.wb_count, 0);
    chk("midrst_ignore_write", wb_if.mem_write, 0);
    step();
    chk("midrst_stay_idle", wb_if.mem_write, 0);

    // Buffer still usable after reset
    push(32'h60, 32'h4444_0060);
    serve_write(1);
    chk("final_empty", wb_if.wb_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
